// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        VALID,
        HALTED
    } state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: sequential, redirect target, or trap vector on a misaligned redirect.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic [XLEN-1:0] i_trap_vector,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_misaligned
);

    always_comb begin
        o_misaligned = i_redirect_valid && ((i_redirect_target[1:0] & ALIGN_MASK) != 2'b00);
        if (o_misaligned) begin
            o_next_pc = i_trap_vector;
        end else if (i_redirect_valid) begin
            o_next_pc = i_redirect_target;
        end else begin
            o_next_pc = i_pc + XLEN'(INSTR_BYTES);
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC, issues single-outstanding fetches and hands instructions to decode
// with valid/stall flow control.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_instr_valid,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_halt_req,
    output logic            o_halted,
    output logic            o_trap_pulse,
    output logic [XLEN-1:0] o_trap_epc,
    output logic [XLEN-1:0] o_instret
);

    state_e          r_state;
    state_e          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_trap_pulse;
    logic [XLEN-1:0] r_trap_epc;
    logic [XLEN-1:0] r_instret;

    logic            w_fetch_done;
    logic            w_consume;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;

    assign w_fetch_done = (r_state == REQ) && i_imem_ready;
    assign w_consume    = (r_state == VALID) && !i_stall;

    pc_next_sel #(
        .XLEN(XLEN)
    ) u_next_sel (
        .i_pc              (r_pc),
        .i_redirect_valid  (i_redirect_valid),
        .i_redirect_target (i_redirect_target),
        .i_trap_vector     (TRAP_VECTOR),
        .o_next_pc         (w_next_pc),
        .o_misaligned      (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    w_state_next = REQ;
            REQ:     if (i_imem_ready) w_state_next = VALID;
            VALID:   if (!i_stall) w_state_next = i_halt_req ? HALTED : REQ;
            HALTED:  w_state_next = HALTED;
            default: w_state_next = IDLE;
        endcase
    end

    // Decoded from state so a reset drops the request without waiting for a clock edge.
    always_comb begin
        o_imem_req = (r_state == REQ);
        o_halted   = (r_state == HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_VECTOR;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_trap_pulse  <= 1'b0;
            r_trap_epc    <= '0;
            r_instret     <= '0;
        end else begin
            r_trap_pulse <= 1'b0;
            if (w_fetch_done) begin
                r_instr       <= i_imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end
            if (w_consume) begin
                r_instret     <= r_instret + XLEN'(1);
                r_instr_valid <= 1'b0;
                // Halt wins over any redirect and freezes the PC.
                if (!i_halt_req) begin
                    r_pc <= w_next_pc;
                    if (w_misaligned) begin
                        r_trap_epc   <= i_redirect_target;
                        r_trap_pulse <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_trap_pulse  = r_trap_pulse;
    assign o_trap_epc    = r_trap_epc;
    assign o_instret     = r_instret;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Fetch-side controller for the core's 32-bit program counter register. It owns the PC state and issues single-outstanding requests to instruction memory with a req/ready handshake. It presents fetched instructions to decode with valid/stall flow control and selects the next PC from sequential, redirect (branch/jump) or trap sources. It sits between instruction memory and the decode/execute stage, and replaces the free-running PC update.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned redirect target is detected
XLEN, 32, address/data width; only 32 is supported

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  instruction fetch request; held until accepted
imem_addr  output  XLEN  fetch address; equals pc, stable while imem_req=1
imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle
imem_rdata  input  XLEN  instruction word, valid when imem_req&imem_ready
instr  output  XLEN  registered instruction to decode
instr_pc  output  XLEN  PC of instr
instr_valid  output  1  instr holds an unconsumed instruction
stall  input  1  decode cannot consume instr this cycle
redirect_valid  input  1  taken branch/jump for the instruction being consumed
redirect_target  input  XLEN  target address of the redirect
halt_req  input  1  stop fetching after the instruction being consumed
halted  output  1  sequencer is in HALTED
trap_pulse  output  1  one-cycle pulse on misaligned redirect
trap_epc  output  XLEN  offending target captured on trap
instret  output  XLEN  count of consumed instructions; wraps modulo 2^32

Behaviour:
- Reset (async, immediate, including mid-handshake):
  - pc=RESET_VECTOR; state=IDLE.
  - imem_req=0, instr=0, instr_pc=0, instr_valid=0, halted=0, trap_pulse=0, trap_epc=0, instret=0.
- States: IDLE, REQ, VALID, HALTED.
- IDLE: lasts one cycle after reset deassertion, then goes to REQ.
- REQ:
  - imem_req=1, imem_addr=pc.
  - When imem_ready=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to VALID.
  - Otherwise stay in REQ with the address held stable.
- VALID:
  - instr_valid=1, imem_req=0.
  - If stall=1: hold every register; redirect_valid and halt_req are ignored.
  - If stall=0 (consume):
    - instret<=instret+1; instr_valid<=0.
    - Next PC priority, applied in this order:
      - halt_req=1: go to HALTED; pc unchanged; redirect ignored.
      - redirect_valid=1 and redirect_target[1:0]!=0: pc<=TRAP_VECTOR, trap_epc<=redirect_target, trap_pulse=1 in the following cycle, go to REQ.
      - redirect_valid=1 and target aligned: pc<=redirect_target, go to REQ.
      - Otherwise: pc<=pc+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), go to REQ.
- HALTED:
  - halted=1, imem_req=0, instr_valid=0.
  - Left only by reset.
- redirect_valid and halt_req are sampled only in VALID with stall=0; in all other states they have no effect.
- Throughput: with imem_ready tied to 1 and stall=0, one instruction every 2 cycles. First imem_req is asserted in cycle 2 after reset release.
- trap_pulse is high for exactly one cycle. trap_epc holds its value until the next trap or reset.
- The PC and instruction registers are 32-bit, rising-edge flops with async active-high clear, matching the existing PC register style.

Decomposition:
- Shared package pc_seq_pkg contains:
  - state enum {IDLE, REQ, VALID, HALTED};
  - INSTR_BYTES=4;
  - ALIGN_MASK=2'b11.
- Sub-module pc_next_sel is purely combinational.
  - Inputs: pc, redirect_valid, redirect_target, TRAP_VECTOR.
  - Outputs: next_pc and misaligned flag.
  - The FSM and registers stay in the top module.

Test Plan:
1. Reset release, imem_ready=1, stall=0, no redirects: imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle; instret=3 after the third consume.
2. imem_ready low for 3 cycles in REQ at pc 0x8: imem_req stays 1 and imem_addr stays 0x8 throughout; instr captured only on the ready cycle.
3. stall=1 for 4 cycles with instr_valid=1 and redirect_valid=1 driven throughout: instr, instr_pc and pc are unchanged; after stall drops with redirect_valid=1, target 0x40, the next imem_addr is 0x40.
4. Redirect to 0x42: trap_pulse high for 1 cycle, trap_epc=0x42, next imem_addr=0x100.
5. halt_req=1 and redirect_valid=1 on the same consume: HALTED, halted=1, no further imem_req, redirect ignored; apply rst to return to imem_addr=0x0.
6. Assert rst while in REQ with imem_ready=0: imem_req drops in the same cycle without waiting for a clock edge; all outputs return to reset values; after release, fetch restarts at RESET_VECTOR.
